// File: rtl/btn_event_pkg.sv
// rtl/btn_event_pkg.sv - shared event codes and FSM state encoding for the button event decoder
//
// Purpose : constants shared by btn_event_decoder and its testbench.
// Contents: EVT_* 2-bit event codes, state_t 3-bit FSM encoding.
package btn_event_pkg;

  localparam logic [1:0] EVT_NONE   = 2'b00;
  localparam logic [1:0] EVT_SHORT  = 2'b01;
  localparam logic [1:0] EVT_DOUBLE = 2'b10;
  localparam logic [1:0] EVT_LONG   = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT2     = 3'd2,
    PRESS2    = 3'd3,
    LONG_HELD = 3'd4
  } state_t;

endpackage

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - clock prescaler producing a one-cycle millisecond tick
//
// Purpose : counts 0..CLK_DIV-1 and asserts o_tick while the count is at CLK_DIV-1.
// Ports   : clk    in  system clock
//           rst_n  in  asynchronous active-low reset
//           i_clr  in  synchronous clear of the prescaler
//           o_tick out one-cycle tick, once every CLK_DIV cycles
module ms_tick_gen #(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] r_cnt;

  assign o_tick = (r_cnt == PW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/btn_event_decoder.sv
// rtl/btn_event_decoder.sv - classifies button presses into SHORT/DOUBLE/LONG events
//
// Purpose : edge detect, press-classification FSM, ms counter and a 1-deep
//           valid/ready event holding register with sticky overflow.
// Ports   : clk       in  system clock
//           rst_n     in  asynchronous active-low reset
//           btn_in    in  debounced, clk-synchronous button level (active high)
//           evt_valid out holding register contains an event
//           evt_ready in  consumer takes the event on evt_valid & evt_ready
//           evt_code  out 01=SHORT 10=DOUBLE 11=LONG, 00 when empty
//           evt_ovf   out sticky: an event was dropped
//           clr_ovf   in  synchronous clear of evt_ovf
//           busy      out FSM not in IDLE
module btn_event_decoder
  import btn_event_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int LONG_MS = 1000,
  parameter int DBL_MS  = 300,
  parameter int CNT_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_code,
  output logic       evt_ovf,
  input  logic       clr_ovf,
  output logic       busy
);

  logic             r_btn_q;
  state_t           r_state;
  logic [CNT_W-1:0] r_ms_cnt;

  state_t           w_next_state;
  logic [CNT_W-1:0] w_ms_next;
  logic             w_tick;
  logic             w_rise;
  logic             w_fall;
  logic             w_state_chg;
  logic             w_long_hit;
  logic             w_dbl_hit;
  logic             w_emit;
  logic [1:0]       w_emit_code;
  logic             w_load;
  logic             w_drop;

  assign w_rise = btn_in & ~r_btn_q;
  assign w_fall = ~btn_in & r_btn_q;

  assign w_ms_next = (r_ms_cnt == {CNT_W{1'b1}}) ? r_ms_cnt : r_ms_cnt + 1'b1;

  // Timeouts fire on the edge where ms_cnt reaches the limit, so a timeout
  // lands exactly LIMIT*CLK_DIV cycles after the state was entered.
  assign w_long_hit = w_tick & (w_ms_next == CNT_W'(LONG_MS));
  assign w_dbl_hit  = w_tick & (w_ms_next == CNT_W'(DBL_MS));

  always_comb begin
    w_next_state = r_state;
    w_emit       = 1'b0;
    w_emit_code  = EVT_NONE;
    case (r_state)
      IDLE: begin
        if (w_rise) w_next_state = PRESS1;
      end
      PRESS1: begin
        if (w_fall) begin
          w_next_state = WAIT2;
        end else if (w_long_hit && btn_in) begin
          w_next_state = LONG_HELD;
          w_emit       = 1'b1;
          w_emit_code  = EVT_LONG;
        end
      end
      LONG_HELD: begin
        if (w_fall) w_next_state = IDLE;
      end
      WAIT2: begin
        // A second press on the timeout edge still counts as a double click.
        if (w_rise) begin
          w_next_state = PRESS2;
        end else if (w_dbl_hit) begin
          w_next_state = IDLE;
          w_emit       = 1'b1;
          w_emit_code  = EVT_SHORT;
        end
      end
      PRESS2: begin
        if (w_fall) begin
          w_next_state = IDLE;
          w_emit       = 1'b1;
          w_emit_code  = EVT_DOUBLE;
        end else if (w_long_hit) begin
          w_next_state = LONG_HELD;
          w_emit       = 1'b1;
          w_emit_code  = EVT_DOUBLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_state_chg = (w_next_state != r_state);
  assign w_load      = w_emit & (~evt_valid | evt_ready);
  assign w_drop      = w_emit & evt_valid & ~evt_ready;

  ms_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_ms_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_state_chg),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_q   <= 1'b1;  // a button held through reset never looks like a press
      r_state   <= IDLE;
      r_ms_cnt  <= '0;
      busy      <= 1'b0;
      evt_valid <= 1'b0;
      evt_code  <= EVT_NONE;
      evt_ovf   <= 1'b0;
    end else begin
      r_btn_q <= btn_in;
      r_state <= w_next_state;
      busy    <= (w_next_state != IDLE);

      if (w_state_chg) begin
        r_ms_cnt <= '0;
      end else if (w_tick) begin
        r_ms_cnt <= w_ms_next;
      end

      if (w_load) begin
        evt_valid <= 1'b1;
        evt_code  <= w_emit_code;
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
        evt_code  <= EVT_NONE;
      end

      if (w_drop) begin
        evt_ovf <= 1'b1;
      end else if (clr_ovf) begin
        evt_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_btn_event_decoder.sv
// tb/tb_btn_event_decoder.sv - scoreboard testbench for btn_event_decoder
module tb_btn_event_decoder;
  import btn_event_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int LONG_MS = 10;
  localparam int DBL_MS  = 5;
  localparam int CNT_W   = 8;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       btn_in    = 1'b0;
  logic       evt_ready = 1'b1;
  logic       clr_ovf   = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ovf;
  logic       busy;

  typedef struct {
    logic [1:0] code;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  btn_event_decoder #(
    .CLK_DIV (CLK_DIV),
    .LONG_MS (LONG_MS),
    .DBL_MS  (DBL_MS),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_in    (btn_in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_ovf   (evt_ovf),
    .clr_ovf   (clr_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_evt(input logic [1:0] code, input int at);
    exp_t e;
    e.code = code;
    e.cyc  = at;
    sb_q.push_back(e);
  endtask

  // Monitor: every accepted event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_evt: got code %0d at cycle %0d, expected no event", evt_code, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("evt_code", 32'(evt_code), 32'(mon_e.code));
        if (mon_e.cyc >= 0) chk("evt_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  int t;
  int r;

  initial begin
    wait_cyc(3);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_code",  32'(evt_code),  0);
    chk("rst_ovf",   32'(evt_ovf),   0);
    chk("rst_busy",  32'(busy),      0);
    rst_n = 1'b1;
    wait_cyc(2);

    // 1. short click: 12 high cycles, SHORT 20 cycles after the release edge
    btn_in = 1'b1;
    wait_cyc(12);
    chk("s1_busy_press", 32'(busy), 1);
    btn_in = 1'b0;
    r = cyc + 1;
    expect_evt(EVT_SHORT, r + 20);
    wait_cyc(30);
    chk("s1_busy_idle", 32'(busy), 0);
    chk("s1_sb_empty", 32'(sb_q.size()), 0);

    // 2. long press: LONG at T+40, nothing on release
    btn_in = 1'b1;
    t = cyc + 1;
    expect_evt(EVT_LONG, t + 40);
    wait_cyc(100);
    chk("s2_busy_held", 32'(busy), 1);
    chk("s2_sb_empty", 32'(sb_q.size()), 0);
    btn_in = 1'b0;
    wait_cyc(3);
    chk("s2_busy_idle", 32'(busy), 0);
    wait_cyc(40);

    // 3. double click: DOUBLE on the second fall
    btn_in = 1'b1;
    wait_cyc(8);
    btn_in = 1'b0;
    wait_cyc(8);
    btn_in = 1'b1;
    wait_cyc(8);
    btn_in = 1'b0;
    expect_evt(EVT_DOUBLE, cyc + 1);
    wait_cyc(30);
    chk("s3_busy_idle", 32'(busy), 0);

    // 4a. second rise sampled on the timeout edge: DOUBLE only
    btn_in = 1'b1;
    wait_cyc(8);
    btn_in = 1'b0;
    r = cyc + 1;
    wait_cyc(20);
    btn_in = 1'b1;
    wait_cyc(8);
    btn_in = 1'b0;
    expect_evt(EVT_DOUBLE, cyc + 1);
    wait_cyc(30);

    // 4b. second rise one cycle late: SHORT, then a fresh PRESS1 and SHORT
    btn_in = 1'b1;
    wait_cyc(8);
    btn_in = 1'b0;
    r = cyc + 1;
    expect_evt(EVT_SHORT, r + 20);
    wait_cyc(21);
    btn_in = 1'b1;
    wait_cyc(4);
    chk("s4b_busy_press1", 32'(busy), 1);
    wait_cyc(4);
    btn_in = 1'b0;
    r = cyc + 1;
    expect_evt(EVT_SHORT, r + 20);
    wait_cyc(30);
    chk("s4b_sb_empty", 32'(sb_q.size()), 0);

    // 5. backpressure: first SHORT held, second dropped, overflow flagged
    evt_ready = 1'b0;
    btn_in = 1'b1;
    wait_cyc(4);
    btn_in = 1'b0;
    r = cyc + 1;
    expect_evt(EVT_SHORT, -1);
    wait_cyc(20);
    chk("s5_valid_before", 32'(evt_valid), 0);
    wait_cyc(1);
    chk("s5_valid_at", 32'(evt_valid), 1);
    chk("s5_code_at", 32'(evt_code), 32'(EVT_SHORT));
    wait_cyc(10);
    chk("s5_ovf_before", 32'(evt_ovf), 0);
    btn_in = 1'b1;
    wait_cyc(4);
    btn_in = 1'b0;
    wait_cyc(30);
    chk("s5_ovf_set", 32'(evt_ovf), 1);
    chk("s5_code_stable", 32'(evt_code), 32'(EVT_SHORT));
    chk("s5_valid_held", 32'(evt_valid), 1);
    clr_ovf = 1'b1;
    wait_cyc(1);
    clr_ovf = 1'b0;
    chk("s5_ovf_clr", 32'(evt_ovf), 0);
    evt_ready = 1'b1;
    wait_cyc(2);
    chk("s5_valid_drain", 32'(evt_valid), 0);
    chk("s5_code_drain", 32'(evt_code), 0);
    chk("s5_sb_empty", 32'(sb_q.size()), 0);

    // 6a. button held through reset release: no press
    rst_n = 1'b0;
    btn_in = 1'b1;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(60);
    chk("s6_held_busy", 32'(busy), 0);
    chk("s6_held_valid", 32'(evt_valid), 0);
    btn_in = 1'b0;
    wait_cyc(5);
    chk("s6_release_busy", 32'(busy), 0);

    // 6b. reset during PRESS1 at ms_cnt=7 aborts without an event
    btn_in = 1'b1;
    wait_cyc(30);
    chk("s6_busy_pre", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("s6_abort_busy",  32'(busy),      0);
    chk("s6_abort_valid", 32'(evt_valid), 0);
    chk("s6_abort_code",  32'(evt_code),  0);
    chk("s6_abort_ovf",   32'(evt_ovf),   0);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(60);
    chk("s6_post_busy", 32'(busy), 0);
    btn_in = 1'b0;
    wait_cyc(30);
    chk("s6_final_busy", 32'(busy), 0);
    chk("final_sb_empty", 32'(sb_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_event_decoder.md
Name: btn_event_decoder

Overview:
- Sits directly downstream of the button debouncer/synchroniser and consumes its clean, clk-synchronous level.
- Classifies each press into one of three events: SHORT click, DOUBLE click or LONG press.
- Presents each event to a register block or interrupt logic through a 1-deep valid/ready holding register.
- Has a sticky overflow flag for events dropped because the consumer did not take the previous one.

Parameters:
- CLK_DIV, 50000: clk cycles per 1 ms tick; must be >= 1.
- LONG_MS, 1000: hold time in ms that qualifies a LONG press; 1 <= LONG_MS < 2^CNT_W.
- DBL_MS, 300: window in ms after a short release in which a second press makes a DOUBLE; 1 <= DBL_MS < 2^CNT_W.
- CNT_W, 16: width of the ms counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- btn_in  in  1  debounced button level, active high, already synchronous to clk.
- evt_valid  out  1  holding register contains an event.
- evt_ready  in  1  consumer accepts the event when evt_valid & evt_ready at a posedge.
- evt_code  out  2  01=SHORT, 10=DOUBLE, 11=LONG; 00 only when evt_valid=0.
- evt_ovf  out  1  sticky: an event was dropped.
- clr_ovf  in  1  synchronous clear of evt_ovf.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values: evt_valid=0, evt_code=00, evt_ovf=0, busy=0, FSM=IDLE, counters=0.
- btn_q (previous sample) resets to 1, so a button already held at reset release generates no press.
- Edge detect: rise = btn_in & ~btn_q; fall = ~btn_in & btn_q.
- Timebase: prescaler counts 0..CLK_DIV-1 and raises tick for one cycle when at CLK_DIV-1; ms_cnt increments on tick.
- Prescaler and ms_cnt are both cleared on every FSM state change, so every timeout is exact.
- ms_cnt saturates at 2^CNT_W-1.
- IDLE: rise -> PRESS1. A fall is ignored.
- PRESS1:
  - fall -> WAIT2.
  - If ms_cnt==LONG_MS and btn_in still high: emit LONG -> LONG_HELD.
- LONG_HELD: fall -> IDLE, no event.
- WAIT2:
  - rise -> PRESS2.
  - If ms_cnt==DBL_MS with no rise: emit SHORT -> IDLE.
  - If the rise and the timeout coincide, the rise wins (-> PRESS2, no SHORT).
- PRESS2:
  - fall: emit DOUBLE -> IDLE.
  - If ms_cnt==LONG_MS first: emit DOUBLE -> LONG_HELD.
  - A fall coinciding with ms_cnt==LONG_MS takes the fall branch.
- Timing (btn_in first sampled high at posedge T; FSM enters PRESS1 at T; held throughout): LONG is visible on evt_valid/evt_code after posedge T + LONG_MS*CLK_DIV.
- SHORT is visible after posedge R + DBL_MS*CLK_DIV, where R is the posedge at which the release is first sampled.
- DOUBLE and SHORT/LONG emission updates the holding register on the posedge of the deciding transition.
- Holding register:
  - An emit loads evt_code and sets evt_valid if evt_valid=0, or if evt_valid & evt_ready in the same cycle (back-to-back with no bubble).
  - Otherwise the new event is dropped, evt_code is unchanged and evt_ovf is set.
  - evt_valid & evt_ready with no emit: evt_valid=0, evt_code=00.
  - evt_code is stable while evt_valid & ~evt_ready.
- evt_ovf: set on a drop, cleared by clr_ovf; if a drop and clr_ovf occur in the same cycle, set wins.
- busy = (FSM != IDLE), registered with the state.
- rst_n assertion mid-operation aborts any pending classification immediately; no event is emitted.

Decomposition:
- Shared package btn_event_pkg: event code constants EVT_NONE/SHORT/DOUBLE/LONG (2 bit) and state encoding IDLE, PRESS1, WAIT2, PRESS2, LONG_HELD (3 bit).
- One sub-module, ms_tick_gen: prescaler with parameter CLK_DIV, synchronous clear input, 1-cycle tick output, same clk/rst_n.
- The FSM, ms_cnt, edge detect and holding register live in btn_event_decoder.

Test Plan:
All scenarios use CLK_DIV=4, LONG_MS=10, DBL_MS=5, CNT_W=8, evt_ready=1 unless stated.
1. Short click: btn_in high 12 cycles then low -> exactly one evt_valid pulse with code 01, 20 cycles after the release posedge; busy returns to 0.
2. Long press: btn_in held high 100 cycles -> code 11 at T+40; no further event on release; busy=0 after the release.
3. Double click: high 8, low 8, high 8, low -> code 10 on the second fall; no SHORT is emitted.
4. WAIT2 boundary: second rise sampled on exactly the timeout posedge -> DOUBLE only (rise wins). Second rise one cycle later -> SHORT then a new PRESS1.
5. Backpressure: evt_ready=0, two short clicks -> first code 01 held stable, second dropped, evt_ovf=1. clr_ovf pulse -> evt_ovf=0. Then evt_ready=1 -> code 01 consumed.
6. Reset: button held at rst_n release -> no event; rst_n pulsed during PRESS1 at ms_cnt=7 -> no event, busy=0, outputs at their reset values.
